alu: RTL and testbench

ALU -- requirements
Module: alu

---
 rtl/alu_pkg.sv | 24 ++
 rtl/alu_core.sv | 45 ++++
 rtl/alu.sv | 44 ++++
 tb/tb_alu.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared width, opcode constants and operand-select helper for the ALU
package alu_pkg;

    localparam int WIDTH = 4;

    localparam logic [2:0] OP_XFER_INC = 3'b000;
    localparam logic [2:0] OP_ADD      = 3'b001;
    localparam logic [2:0] OP_SUB      = 3'b010;
    localparam logic [2:0] OP_DEC      = 3'b011;
    localparam logic [2:0] OP_AND_OR   = 3'b100;
    localparam logic [2:0] OP_XOR_NOT  = 3'b101;
    localparam logic [2:0] OP_SHL      = 3'b110;
    localparam logic [2:0] OP_SHR      = 3'b111;

    // Second adder operand: 0, B, ~B or all-ones depending on the arithmetic op.
    // Non-arithmetic ops yield 0; their adder output is never selected.
    function automatic logic [WIDTH-1:0] y_sel(input logic [2:0] op, input logic [WIDTH-1:0] b);
        return op == OP_ADD ? b
             : op == OP_SUB ? ~b
             : op == OP_DEC ? {WIDTH{1'b1}}
             : {WIDTH{1'b0}};
    endfunction

endpackage

// File: rtl/alu_core.sv
// alu_core: combinational ALU datapath (adder with Y-mux, logic unit, shifter, result mux)
//   a, b : operands (unsigned)
//   s    : operation select
//   cin  : carry-in / operation modifier / shift-in bit
//   f    : result
//   cout : carry-out (arithmetic), shifted-out bit (shifts), 0 (logic)
module alu_core
    import alu_pkg::*;
(
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       s,
    input  logic             cin,
    output logic [WIDTH-1:0] f,
    output logic             cout
);

    logic [WIDTH:0] sum;

    always_comb begin
        sum  = {1'b0, a} + {1'b0, y_sel(s, b)} + {{WIDTH{1'b0}}, cin};
        f    = sum[WIDTH-1:0];
        cout = sum[WIDTH];
        case (s)
            OP_AND_OR: begin
                f    = cin ? (a | b) : (a & b);
                cout = 1'b0;
            end
            OP_XOR_NOT: begin
                f    = cin ? ~a : (a ^ b);
                cout = 1'b0;
            end
            OP_SHL: begin
                f    = {a[WIDTH-2:0], cin};
                cout = a[WIDTH-1];
            end
            OP_SHR: begin
                f    = {cin, a[WIDTH-1:1]};
                cout = a[0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu.sv
// alu: registered 4-bit ALU, one-cycle latency from inputs to F/Cout
//   clk   : rising-edge clock
//   reset : synchronous active-high reset, clears F and Cout
//   A, B  : operands
//   S     : operation select
//   Cin   : carry-in / modifier
//   F     : registered result
//   Cout  : registered carry/shift-out flag
module alu
    import alu_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       S,
    input  logic             Cin,
    output logic [WIDTH-1:0] F,
    output logic             Cout
);

    logic [WIDTH-1:0] f_next;
    logic             cout_next;

    alu_core u_core (
        .a    (A),
        .b    (B),
        .s    (S),
        .cin  (Cin),
        .f    (f_next),
        .cout (cout_next)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            F    <= '0;
            Cout <= 1'b0;
        end else begin
            F    <= f_next;
            Cout <= cout_next;
        end
    end

endmodule

// File: tb/tb_alu.sv
// tb_alu: self-checking bench for alu against an arithmetic reference model
module tb_alu;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] A = '0;
    logic [3:0] B = '0;
    logic [2:0] S = '0;
    logic       Cin = 1'b0;
    logic [3:0] F;
    logic       Cout;

    int total = 0;
    int bad = 0;

    alu dut (
        .clk   (clk),
        .reset (reset),
        .A     (A),
        .B     (B),
        .S     (S),
        .Cin   (Cin),
        .F     (F),
        .Cout  (Cout)
    );

    always #5 clk = ~clk;

    // Reference: returns {Cout, F} computed with plain integer arithmetic.
    function automatic logic [4:0] model(input int a, input int b, input int s, input int c);
        int r;
        case (s)
            0: r = a + c;
            1: r = a + b + c;
            2: r = a + (15 - b) + c;
            3: r = a + 15 + c;
            4: r = c ? (a | b) : (a & b);
            5: r = c ? (15 - a) : (a ^ b);
            6: r = (a * 2) % 16 + c + (a / 8) * 16;
            default: r = c * 8 + a / 2 + (a % 2) * 16;
        endcase
        return 5'(r);
    endfunction

    task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic [2:0] s, input logic c);
        A = a;
        B = b;
        S = s;
        Cin = c;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        drive(4'b1111, 4'b1111, 3'b001, 1'b1);
        total++;
        if ({Cout, F} !== 5'b0_0000) begin
            bad++;
            $display("FAIL reset: got Cout=%b F=%b expected Cout=0 F=0000", Cout, F);
        end
        reset = 1'b0;
    endtask

    task automatic test_directed;
        logic [3:0] a [12] = '{4'b1001, 4'b1001, 4'b0101, 4'b0111, 4'b1111, 4'b0000,
                               4'b1100, 4'b1100, 4'b1100, 4'b1100, 4'b1011, 4'b1011};
        logic [3:0] b [12] = '{4'b1000, 4'b1000, 4'b0111, 4'b0101, 4'b0000, 4'b0000,
                               4'b1010, 4'b1010, 4'b1010, 4'b1010, 4'b0000, 4'b0000};
        logic [2:0] s [12] = '{3'b001, 3'b001, 3'b010, 3'b010, 3'b000, 3'b011,
                               3'b100, 3'b100, 3'b101, 3'b101, 3'b110, 3'b111};
        logic       c [12] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0,
                               1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [4:0] e [12] = '{5'b1_0001, 5'b1_0010, 5'b0_1110, 5'b1_0010, 5'b1_0000, 5'b0_1111,
                               5'b0_1000, 5'b0_1110, 5'b0_0110, 5'b0_0011, 5'b1_0111, 5'b1_0101};
        for (int i = 0; i < 12; i++) begin
            drive(a[i], b[i], s[i], c[i]);
            total++;
            if ({Cout, F} !== e[i]) begin
                bad++;
                $display("FAIL directed[%0d]: got Cout=%b F=%b expected Cout=%b F=%b",
                         i, Cout, F, e[i][4], e[i][3:0]);
            end
        end
    endtask

    task automatic test_sweep;
        logic [11:0] v;
        logic [4:0]  exp;
        for (int i = 0; i < 4096; i++) begin
            v = 12'(i);
            exp = model(int'(v[11:8]), int'(v[7:4]), int'(v[3:1]), int'(v[0]));
            drive(v[11:8], v[7:4], v[3:1], v[0]);
            total++;
            if ({Cout, F} !== exp) begin
                bad++;
                $display("FAIL sweep A=%b B=%b S=%b Cin=%b: got Cout=%b F=%b expected Cout=%b F=%b",
                         v[11:8], v[7:4], v[3:1], v[0], Cout, F, exp[4], exp[3:0]);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [3:0] a, b;
        logic [2:0] s;
        logic       c;
        logic [4:0] exp;
        for (int i = 0; i < 500; i++) begin
            a = 4'($urandom);
            b = 4'($urandom);
            s = 3'($urandom);
            c = 1'($urandom);
            exp = model(int'(a), int'(b), int'(s), int'(c));
            drive(a, b, s, c);
            total++;
            if ({Cout, F} !== exp) begin
                bad++;
                $display("FAIL random A=%b B=%b S=%b Cin=%b: got Cout=%b F=%b expected Cout=%b F=%b",
                         a, b, s, c, Cout, F, exp[4], exp[3:0]);
            end
        end
    endtask

    task automatic test_mid_reset;
        drive(4'b1111, 4'b0001, 3'b001, 1'b1);
        total++;
        if ({Cout, F} !== 5'b1_0001) begin
            bad++;
            $display("FAIL pre_reset: got Cout=%b F=%b expected Cout=1 F=0001", Cout, F);
        end
        // Reset pulsed between edges must not disturb the registered outputs.
        reset = 1'b1;
        #2;
        total++;
        if ({Cout, F} !== 5'b1_0001) begin
            bad++;
            $display("FAIL reset_between_edges: got Cout=%b F=%b expected Cout=1 F=0001", Cout, F);
        end
        reset = 1'b0;
        #1;
        reset = 1'b1;
        drive(4'b0111, 4'b0101, 3'b010, 1'b1);
        total++;
        if ({Cout, F} !== 5'b0_0000) begin
            bad++;
            $display("FAIL mid_reset: got Cout=%b F=%b expected Cout=0 F=0000", Cout, F);
        end
        reset = 1'b0;
        drive(4'b0111, 4'b0101, 3'b010, 1'b1);
        total++;
        if ({Cout, F} !== 5'b1_0010) begin
            bad++;
            $display("FAIL post_reset: got Cout=%b F=%b expected Cout=1 F=0010", Cout, F);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_sweep();
        test_back_to_back();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
